// File: rtl/board_port_arbiter.sv
// board_port_arbiter: request/grant arbiter for board-memory RAM port B.
// One access per cycle onto a registered port; read data routed back by channel.
module board_port_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MODE       = 1,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH-1:0]        lock,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_q,
  output logic                     busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NS = RD_LATENCY + 1;
  localparam int LW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     owner_q, owner_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     last_q, last_d;
  logic              excl_v_q, excl_v_d;
  logic [CW-1:0]     excl_id_q, excl_id_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwd_q, mwd_d;
  logic              mwe_q, mwe_d;
  logic              busy_q, busy_d;
  logic [NS-1:0]     pv_q, pv_d;
  logic [CW-1:0]     pid_q [NS];
  logic [CW-1:0]     pid_d [NS];

  logic [NUM_CH-1:0] cand;
  logic              gv;
  logic [CW-1:0]     gid;
  int                rr_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Locked owner blocks everyone else; a forced unlock benches the owner once.
  always_comb begin
    cand = '0;
    if (!reset) begin
      if (state_q == S_LOCKED) begin
        cand[owner_q] = req[owner_q];
      end else begin
        cand = req;
        if (excl_v_q) cand[excl_id_q] = 1'b0;
      end
    end
  end

  always_comb begin
    gv     = 1'b0;
    gid    = '0;
    rr_idx = 0;
    if (MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (cand[CW'(i)]) begin
          gv  = 1'b1;
          gid = CW'(i);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        rr_idx = int'(last_q) + k;
        if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
        if (cand[CW'(rr_idx)]) begin
          gv  = 1'b1;
          gid = CW'(rr_idx);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gv) gnt[gid] = 1'b1;
  end

  assign sel_addr  = addr[int'(gid)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(gid)*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    excl_v_d  = 1'b0;
    excl_id_d = excl_id_q;
    maddr_d   = maddr_q;
    mwd_d     = mwd_q;
    mwe_d     = 1'b0;
    if (gv) begin
      last_d  = gid;
      maddr_d = sel_addr;
      mwd_d   = sel_wdata;
      mwe_d   = we[gid];
    end
    unique case (state_q)
      S_IDLE: begin
        if (gv && lock[gid]) begin
          state_d = S_LOCKED;
          owner_d = gid;
          cnt_d   = LW'(1);
        end
      end
      S_LOCKED: begin
        if (!gv || !lock[owner_q]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LW'(LOCK_MAX - 1)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          excl_v_d  = 1'b1;
          excl_id_d = owner_q;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pv_d     = {pv_q[NS-2:0], gv && !we[gid]};
    pid_d[0] = gid;
    for (int i = 1; i < NS; i++) pid_d[i] = pid_q[i-1];
    busy_d = (|pv_d) || (state_d == S_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      cnt_q     <= '0;
      last_q    <= CW'(NUM_CH - 1);
      excl_v_q  <= 1'b0;
      excl_id_q <= '0;
      maddr_q   <= '0;
      mwd_q     <= '0;
      mwe_q     <= 1'b0;
      busy_q    <= 1'b0;
      pv_q      <= '0;
      for (int i = 0; i < NS; i++) pid_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      excl_v_q  <= excl_v_d;
      excl_id_q <= excl_id_d;
      maddr_q   <= maddr_d;
      mwd_q     <= mwd_d;
      mwe_q     <= mwe_d;
      busy_q    <= busy_d;
      pv_q      <= pv_d;
      for (int i = 0; i < NS; i++) pid_q[i] <= pid_d[i];
    end
  end

  always_comb begin
    rvalid = '0;
    if (pv_q[NS-1]) rvalid[pid_q[NS-1]] = 1'b1;
  end

  assign rdata     = mem_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwd_q;
  assign mem_we    = mwe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_board_port_arbiter.sv
// tb_board_port_arbiter: round-robin and fixed-priority instances side by side,
// checked every cycle against a transaction-level model plus literal vectors.
module tb_board_port_arbiter;

  localparam int RDL  = 1;
  localparam int LMAX = 16;

  localparam logic [2:0] RRG [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  localparam logic [2:0] RRV [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
  localparam int         RRA [6] = '{0, 0, 5, 6, 7, 5};

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_init;
  logic [2:0]  req, we, lock;
  logic [35:0] addr_p;
  logic [95:0] wdata_p;

  logic [2:0]  gnt_w [2];
  logic [2:0]  rv_w  [2];
  logic [31:0] rd_w  [2];
  logic [11:0] ma    [2];
  logic [31:0] mwd   [2];
  logic        mwe   [2];
  logic        bsy   [2];
  logic [31:0] mq    [2];
  logic [31:0] ram   [2][4096];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  board_port_arbiter #(.NUM_CH(3), .ADDR_W(12), .DATA_W(32), .MODE(1),
    .RD_LATENCY(RDL), .LOCK_MAX(LMAX)) u_rr (
    .clock(clk), .reset(rst), .req(req), .we(we), .lock(lock),
    .addr(addr_p), .wdata(wdata_p), .gnt(gnt_w[0]), .rvalid(rv_w[0]),
    .rdata(rd_w[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]),
    .mem_we(mwe[0]), .mem_q(mq[0]), .busy(bsy[0]));

  board_port_arbiter #(.NUM_CH(3), .ADDR_W(12), .DATA_W(32), .MODE(0),
    .RD_LATENCY(RDL), .LOCK_MAX(LMAX)) u_fx (
    .clock(clk), .reset(rst), .req(req), .we(we), .lock(lock),
    .addr(addr_p), .wdata(wdata_p), .gnt(gnt_w[1]), .rvalid(rv_w[1]),
    .rdata(rd_w[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]),
    .mem_we(mwe[1]), .mem_q(mq[1]), .busy(bsy[1]));

  function automatic logic [31:0] f(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // RAM behind each port: one registered read stage
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_init) begin
        for (int a = 0; a < 4096; a++) ram[d][a] <= f(a);
      end else if (mwe[d]) begin
        ram[d][ma[d]] <= mwd[d];
      end
      mq[d] <= ram[d][ma[d]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          d;
    int          due;
    int          ch;
    logic [31:0] data;
  } pend_t;

  pend_t       pq[$];
  pend_t       pe;
  logic [31:0] mm [2][4096];
  bit          m_locked [2];
  int          m_owner [2], m_cnt [2], m_last [2], m_excl [2];
  logic [11:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic        m_we [2], m_busy [2];
  bit          armed = 0;
  int          cyc = 0;
  int          eg, j, nx, npend;
  logic [2:0]  e_g, e_rv;
  logic [31:0] e_rd;
  bit          have;
  logic [11:0] ta;
  logic [31:0] tw;

  // Model: compare this cycle, then advance to the next
  task automatic model_cmp();
    for (int d = 0; d < 2; d++) begin
      eg = -1;
      if (!rst) begin
        if (m_locked[d]) begin
          if (req[m_owner[d]]) eg = m_owner[d];
        end else if (d == 1) begin
          for (int i = 0; i < 3; i++)
            if (req[i] && i != m_excl[d]) begin eg = i; break; end
        end else begin
          for (int k = 1; k <= 3; k++) begin
            j = (m_last[d] + k) % 3;
            if (req[j] && j != m_excl[d]) begin eg = j; break; end
          end
        end
      end
      e_g = (eg < 0) ? 3'b000 : 3'(1 << eg);
      chk($sformatf("gnt[%0d] cyc %0d", d, cyc), 64'(gnt_w[d]), 64'(e_g));
      if (armed) begin
        chk($sformatf("mem_we[%0d] cyc %0d", d, cyc), 64'(mwe[d]), 64'(m_we[d]));
        chk($sformatf("mem_addr[%0d] cyc %0d", d, cyc), 64'(ma[d]), 64'(m_addr[d]));
        chk($sformatf("mem_wdata[%0d] cyc %0d", d, cyc), 64'(mwd[d]), 64'(m_wd[d]));
        chk($sformatf("busy[%0d] cyc %0d", d, cyc), 64'(bsy[d]), 64'(m_busy[d]));
        e_rv = '0; e_rd = '0; have = 0;
        for (int k = 0; k < pq.size(); k++) begin
          if (pq[k].d == d) begin
            if (pq[k].due == cyc) begin
              e_rv = 3'(1 << pq[k].ch);
              e_rd = pq[k].data;
              have = 1;
              pq.delete(k);
            end
            break;
          end
        end
        chk($sformatf("rvalid[%0d] cyc %0d", d, cyc), 64'(rv_w[d]), 64'(e_rv));
        if (have) chk($sformatf("rdata[%0d] cyc %0d", d, cyc), 64'(rd_w[d]), 64'(e_rd));
      end
      if (rst) begin
        m_locked[d] = 0; m_owner[d] = 0; m_cnt[d] = 0;
        m_last[d] = 2; m_excl[d] = -1;
        m_addr[d] = '0; m_wd[d] = '0; m_we[d] = 0; m_busy[d] = 0;
        for (int k = pq.size() - 1; k >= 0; k--)
          if (pq[k].d == d) pq.delete(k);
      end else begin
        nx = -1;
        if (eg >= 0) begin
          ta = addr_p[eg*12 +: 12];
          tw = wdata_p[eg*32 +: 32];
          m_addr[d] = ta; m_wd[d] = tw; m_we[d] = we[eg]; m_last[d] = eg;
          if (we[eg]) begin
            mm[d][ta] = tw;
          end else begin
            pe.d = d; pe.due = cyc + 1 + RDL; pe.ch = eg; pe.data = mm[d][ta];
            pq.push_back(pe);
          end
        end else begin
          m_we[d] = 0;
        end
        if (!m_locked[d]) begin
          if (eg >= 0 && lock[eg]) begin
            m_locked[d] = 1; m_owner[d] = eg; m_cnt[d] = 1;
          end
        end else if (eg < 0) begin
          m_locked[d] = 0; m_cnt[d] = 0;
        end else begin
          m_cnt[d]++;
          if (!lock[eg]) begin
            m_locked[d] = 0; m_cnt[d] = 0;
          end else if (m_cnt[d] == LMAX) begin
            m_locked[d] = 0; m_cnt[d] = 0; nx = eg;
          end
        end
        m_excl[d] = nx;
        npend = 0;
        foreach (pq[k]) if (pq[k].d == d) npend++;
        m_busy[d] = (npend > 0) || m_locked[d];
      end
    end
    if (rst) armed = 1;
    cyc++;
  endtask

  task automatic mid();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin mid(); tick(); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 4096; a++) mm[d][a] = f(a);
    rst = 1; ram_init = 1;
    req = 3'b111; we = 3'b000; lock = 3'b000;
    addr_p = {12'd7, 12'd6, 12'd5}; wdata_p = '0;

    mid();
    for (int d = 0; d < 2; d++) chk("reset gnt", 64'(gnt_w[d]), 64'h0);
    tick(); ram_init = 0;
    mid();
    for (int d = 0; d < 2; d++) chk("reset gnt", 64'(gnt_w[d]), 64'h0);
    tick(); rst = 0;

    // round-robin rotation over three readers
    for (int i = 0; i < 6; i++) begin
      if (i == 4) req = 3'b000;
      mid();
      if (i == 0) begin
        for (int d = 0; d < 2; d++) begin
          chk("post-reset gnt", 64'(gnt_w[d]), 64'h1);
          chk("post-reset mem_addr", 64'(ma[d]), 64'h0);
          chk("post-reset mem_wdata", 64'(mwd[d]), 64'h0);
          chk("post-reset mem_we", 64'(mwe[d]), 64'h0);
          chk("post-reset busy", 64'(bsy[d]), 64'h0);
        end
      end
      if (i < 4) chk($sformatf("rr gnt %0d", i), 64'(gnt_w[0]), 64'(RRG[i]));
      if (i >= 2) begin
        chk($sformatf("rr rvalid %0d", i), 64'(rv_w[0]), 64'(RRV[i]));
        chk($sformatf("rr rdata %0d", i), 64'(rd_w[0]), 64'(f(RRA[i])));
      end
      tick();
    end
    idle(2);

    // fixed priority: channel 1 always beats channel 2
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("fixed gnt %0d", i), 64'(gnt_w[1]), 64'h2);
      tick();
    end
    req = 3'b000;
    idle(3);

    // locked write burst from channel 0 against a reader on channel 1
    addr_p = {12'd0, 12'd30, 12'd30};
    wdata_p = {32'h0, 32'h0, 32'h49};
    we = 3'b001; lock = 3'b001; req = 3'b011;
    for (int i = 0; i < 20; i++) begin
      mid();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("lock gnt[%0d] %0d", d, i), 64'(gnt_w[d]),
            (i == 16) ? 64'h2 : 64'h1);
        if (i == 5) chk("lock busy", 64'(bsy[d]), 64'h1);
        if (i == 18) begin
          chk("lock rvalid", 64'(rv_w[d]), 64'h2);
          chk("lock rdata", 64'(rd_w[d]), 64'h49);
        end
      end
      tick();
    end
    req = 3'b000; lock = 3'b000; we = 3'b000;
    idle(4);

    // reset while a read is in flight and a write is being requested
    addr_p[23:12] = 12'd6;
    req = 3'b010;
    mid();
    for (int d = 0; d < 2; d++) chk("pre-reset gnt", 64'(gnt_w[d]), 64'h2);
    tick();
    rst = 1; req = 3'b001; we = 3'b001;
    addr_p[11:0] = 12'd40; wdata_p[31:0] = 32'd77;
    mid();
    for (int d = 0; d < 2; d++) chk("in-reset gnt", 64'(gnt_w[d]), 64'h0);
    tick();
    rst = 0; req = 3'b000; we = 3'b000;
    for (int i = 0; i < 4; i++) begin
      mid();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("after-reset rvalid %0d", i), 64'(rv_w[d]), 64'h0);
        chk($sformatf("after-reset busy %0d", i), 64'(bsy[d]), 64'h0);
        chk($sformatf("after-reset mem_we %0d", i), 64'(mwe[d]), 64'h0);
      end
      tick();
    end

    // single channel write then read of the same word
    addr_p[35:24] = 12'd100; wdata_p[95:64] = 32'hDEAD_BEEF;
    req = 3'b100; we = 3'b100;
    mid();
    for (int d = 0; d < 2; d++) chk("wr gnt", 64'(gnt_w[d]), 64'h4);
    tick();
    we = 3'b000;
    mid();
    for (int d = 0; d < 2; d++) begin
      chk("rd gnt", 64'(gnt_w[d]), 64'h4);
      chk("wr mem_we", 64'(mwe[d]), 64'h1);
      chk("wr mem_addr", 64'(ma[d]), 64'd100);
    end
    tick();
    req = 3'b000;
    mid();
    for (int d = 0; d < 2; d++) chk("rd mem_we", 64'(mwe[d]), 64'h0);
    tick();
    mid();
    for (int d = 0; d < 2; d++) begin
      chk("raw rvalid", 64'(rv_w[d]), 64'h4);
      chk("raw rdata", 64'(rd_w[d]), 64'hDEAD_BEEF);
    end
    tick();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
